fetch_prefetch_buf: RTL and testbench

//  Instruction prefetch buffer between the instruction memory and fetch_top. It issues sequential

---
 rtl/fetch_prefetch_buf_pkg.sv | 15 +
 rtl/fetch_pfb_fifo.sv | 55 +++++
 rtl/fetch_prefetch_buf.sv | 108 ++++++++++
 tb/tb_fetch_prefetch_buf.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_prefetch_buf_pkg.sv
// Shared types and constants for the instruction prefetch buffer.
package fetch_prefetch_buf_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } pfb_entry_t;

  localparam logic [31:0] PFB_PC_INC = 32'd4;

  function automatic logic [31:0] pfb_align(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_pfb_fifo.sv
// DEPTH-entry {pc, inst} ring buffer with head/tail pointers and synchronous clear.
module fetch_pfb_fifo
  import fetch_prefetch_buf_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       wr_en,
  input  pfb_entry_t                 wr_data,
  input  logic                       rd_en,
  output pfb_entry_t                 rd_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  pfb_entry_t       mem_q [DEPTH];
  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic [CNT_W-1:0] cnt_q;

  // Storage is cleared on reset so the head reads as zero before the first write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (clr) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (wr_en) begin
        mem_q[tail_q] <= wr_data;
        tail_q        <= tail_q + PTR_ONE;
      end
      if (rd_en) head_q <= head_q + PTR_ONE;
      case ({wr_en, rd_en})
        2'b10:   cnt_q <= cnt_q + CNT_ONE;
        2'b01:   cnt_q <= cnt_q - CNT_ONE;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign rd_data = mem_q[head_q];
  assign count   = cnt_q;

endmodule

// File: rtl/fetch_prefetch_buf.sv
// Instruction prefetch buffer: sequential fetch requests, credit and redirect-drop logic.
// Optional same-cycle response bypass to fq_* when FETCH_PFB_BYPASS_EN is defined.
module fetch_prefetch_buf
  import fetch_prefetch_buf_pkg::*;
#(
  parameter int          DEPTH  = 4,
  parameter logic [31:0] RST_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mreq_vld,
  input  logic        mreq_rdy,
  output logic [31:0] mreq_addr,
  input  logic        mrsp_vld,
  input  logic [31:0] mrsp_dat,
  output logic        fq_vld,
  output logic [31:0] fq_pc,
  output logic [31:0] fq_inst,
  input  logic        fq_pop,
  input  logic        redir_vld,
  input  logic [31:0] redir_pc
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W:0]   DEPTH_W = (CNT_W + 1)'(DEPTH);

  logic [31:0]      req_pc_q;
  logic [31:0]      exp_pc_q;
  logic [CNT_W-1:0] inflight_q;
  logic [CNT_W-1:0] drop_cnt_q;
  logic             run_q;

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] inflight_nxt;
  logic [CNT_W:0]   occ;
  logic             fire;
  logic             rsp_drop;
  logic             rsp_acc;
  logic             fifo_wr;
  logic             fifo_rd;
  pfb_entry_t       head;
  pfb_entry_t       rsp_entry;

  // Credit counts buffered entries plus live (non-dropped) outstanding requests.
  assign occ       = {1'b0, count} + {1'b0, inflight_q} - {1'b0, drop_cnt_q};
  assign mreq_vld  = run_q && (occ < DEPTH_W);
  assign mreq_addr = req_pc_q;
  assign fire      = mreq_vld && mreq_rdy;

  assign rsp_drop  = (drop_cnt_q != '0);
  assign rsp_acc   = mrsp_vld && !rsp_drop && !redir_vld;
  assign rsp_entry = '{pc: exp_pc_q, inst: mrsp_dat};

  assign inflight_nxt = inflight_q + {{(CNT_W-1){1'b0}}, fire}
                                   - {{(CNT_W-1){1'b0}}, mrsp_vld};

`ifdef FETCH_PFB_BYPASS_EN
  logic byp;
  assign byp     = (count == '0) && rsp_acc;
  assign fq_vld  = (count != '0) || byp;
  assign fq_pc   = byp ? exp_pc_q : head.pc;
  assign fq_inst = byp ? mrsp_dat : head.inst;
  assign fifo_wr = rsp_acc && !(byp && fq_pop);
`else
  assign fq_vld  = (count != '0);
  assign fq_pc   = head.pc;
  assign fq_inst = head.inst;
  assign fifo_wr = rsp_acc;
`endif

  assign fifo_rd = fq_pop && (count != '0) && !redir_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q      <= 1'b0;
      req_pc_q   <= RST_PC;
      exp_pc_q   <= RST_PC;
      inflight_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      run_q      <= 1'b1;
      inflight_q <= inflight_nxt;
      if (redir_vld) begin
        // Everything still outstanding after this cycle belongs to the old stream.
        req_pc_q   <= pfb_align(redir_pc);
        exp_pc_q   <= pfb_align(redir_pc);
        drop_cnt_q <= inflight_nxt;
      end else begin
        if (fire)    req_pc_q <= req_pc_q + PFB_PC_INC;
        if (rsp_acc) exp_pc_q <= exp_pc_q + PFB_PC_INC;
        if (mrsp_vld && rsp_drop) drop_cnt_q <= drop_cnt_q - CNT_ONE;
      end
    end
  end

  fetch_pfb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (redir_vld),
    .wr_en   (fifo_wr),
    .wr_data (rsp_entry),
    .rd_en   (fifo_rd),
    .rd_data (head),
    .count   (count)
  );

endmodule

// File: tb/tb_fetch_prefetch_buf.sv
// Self-checking bench for fetch_prefetch_buf: memory model, fetch-order scoreboard, vector table.
module tb_fetch_prefetch_buf;

`ifdef FETCH_PFB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mreq_vld;
  logic        mreq_rdy;
  logic [31:0] mreq_addr;
  logic        mrsp_vld;
  logic [31:0] mrsp_dat;
  logic        fq_vld;
  logic [31:0] fq_pc;
  logic [31:0] fq_inst;
  logic        fq_pop;
  logic        redir_vld;
  logic [31:0] redir_pc;

  fetch_prefetch_buf #(.DEPTH(DEPTH), .RST_PC(32'h0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mreq_vld  (mreq_vld),
    .mreq_rdy  (mreq_rdy),
    .mreq_addr (mreq_addr),
    .mrsp_vld  (mrsp_vld),
    .mrsp_dat  (mrsp_dat),
    .fq_vld    (fq_vld),
    .fq_pc     (fq_pc),
    .fq_inst   (fq_inst),
    .fq_pop    (fq_pop),
    .redir_vld (redir_vld),
    .redir_pc  (redir_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mem_t;

  typedef struct {
    bit          pop;
    bit          exp_mvld;
    logic [31:0] exp_addr;
    bit          exp_fvld;
    logic [31:0] exp_pc;
  } vec_t;

  mem_t        memq[$];
  logic [31:0] expq[$];
  logic [31:0] req_exp;
  int          cyc;
  int          lat;
  int          n_checks;
  int          n_fail;
  vec_t        vecs[12];

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return 32'h0000_0013 + (a << 5);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Drive memory response, then sample at negedge and update the scoreboard.
  task automatic tick_a();
    if (memq.size() != 0 && memq[0].due <= cyc) begin
      mrsp_vld = 1'b1;
      mrsp_dat = mem_f(memq[0].addr);
      void'(memq.pop_front());
    end else begin
      mrsp_vld = 1'b0;
      mrsp_dat = $urandom;
    end
    @(negedge clk);
    if (mreq_vld && mreq_rdy) begin
      chk("req_addr", mreq_addr, req_exp);
      memq.push_back('{addr: mreq_addr, due: cyc + lat});
      if (!redir_vld) begin
        expq.push_back(mreq_addr);
        req_exp = req_exp + 32'd4;
      end
    end
    if (fq_vld && fq_pop && !redir_vld) begin
      if (expq.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_underflow: got pc %h expected no entry", fq_pc);
      end else begin
        chk("sb_fq_pc", fq_pc, expq[0]);
        chk("sb_fq_inst", fq_inst, mem_f(expq[0]));
        void'(expq.pop_front());
      end
    end
    if (redir_vld) begin
      expq.delete();
      req_exp = {redir_pc[31:2], 2'b00};
    end
    n_checks++;
    if (expq.size() > DEPTH) begin
      n_fail++;
      $display("FAIL credit_overflow: got %0d outstanding expected <= %0d", expq.size(), DEPTH);
    end
  endtask

  task automatic tick_b();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic tick();
    tick_a();
    tick_b();
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    mreq_rdy  = 1'b0;
    fq_pop    = 1'b0;
    redir_vld = 1'b0;
    redir_pc  = '0;
    mrsp_vld  = 1'b0;
    mrsp_dat  = '0;
    memq.delete();
    expq.delete();
    req_exp = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold_mreq_vld", mreq_vld, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mreq_vld", mreq_vld, 0);
    chk("rst_fq_vld", fq_vld, 0);
    chk("rst_fq_pc", fq_pc, 0);
    chk("rst_fq_inst", fq_inst, 0);
    @(posedge clk);
    #1;
    cyc = 0;
  endtask

  task automatic wait_first_pc(input string nm, input logic [31:0] exp, input int budget);
    bit found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      tick_a();
      if (fq_vld) begin
        chk(nm, fq_pc, exp);
        found = 1'b1;
      end
      tick_b();
    end
    if (!found) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: got no fq_vld in %0d cycles expected pc %h", nm, budget, exp);
    end
  endtask

  initial begin
    //        pop mvld addr    fvld  pc
    vecs[0]  = '{0, 1, 32'd0,  0,   32'd0};
    vecs[1]  = '{0, 1, 32'd4,  BYP, 32'd0};
    vecs[2]  = '{0, 1, 32'd8,  1,   32'd0};
    vecs[3]  = '{0, 1, 32'd12, 1,   32'd0};
    vecs[4]  = '{0, 0, 32'd0,  1,   32'd0};
    vecs[5]  = '{0, 0, 32'd0,  1,   32'd0};
    vecs[6]  = '{1, 0, 32'd0,  1,   32'd0};
    vecs[7]  = '{1, 1, 32'd16, 1,   32'd4};
    vecs[8]  = '{1, 1, 32'd20, 1,   32'd8};
    vecs[9]  = '{1, 1, 32'd24, 1,   32'd12};
    vecs[10] = '{1, 1, 32'd28, 1,   32'd16};
    vecs[11] = '{1, 1, 32'd32, 1,   32'd20};
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    lat      = 1;

    // Streaming with 1-cycle memory; also response-to-fetch latency on an empty buffer.
    do_reset();
    mreq_rdy = 1'b1;
    fq_pop   = 1'b1;
    tick();
    tick_a();
    chk("t6_same_cycle_vld", fq_vld, BYP);
    chk("t6_same_cycle_pc", fq_pc, 32'h0);
    chk("t6_same_cycle_inst", fq_inst, BYP ? 32'h0000_0013 : 32'h0);
    tick_b();
    tick_a();
    chk("t6_next_cycle_vld", fq_vld, 1);
    chk("t6_next_cycle_pc", fq_pc, BYP ? 32'h4 : 32'h0);
    tick_b();
    repeat (20) tick();

    // Fill to full with no pops, then resume.
    do_reset();
    lat      = 1;
    mreq_rdy = 1'b1;
    for (int i = 0; i < 12; i++) begin
      fq_pop = vecs[i].pop;
      tick_a();
      chk($sformatf("t2_mreq_vld[%0d]", i), mreq_vld, vecs[i].exp_mvld);
      if (vecs[i].exp_mvld) chk($sformatf("t2_mreq_addr[%0d]", i), mreq_addr, vecs[i].exp_addr);
      chk($sformatf("t2_fq_vld[%0d]", i), fq_vld, vecs[i].exp_fvld);
      if (vecs[i].exp_fvld) chk($sformatf("t2_fq_pc[%0d]", i), fq_pc, vecs[i].exp_pc);
      tick_b();
    end
    repeat (8) tick();

    // 3-cycle memory, two requests in flight, redirect to 0x100.
    do_reset();
    lat      = 3;
    mreq_rdy = 1'b1;
    fq_pop   = 1'b1;
    tick();
    tick();
    mreq_rdy  = 1'b0;
    redir_vld = 1'b1;
    redir_pc  = 32'h0000_0100;
    tick();
    redir_vld = 1'b0;
    mreq_rdy  = 1'b1;
    tick_a();
    chk("t3_fq_vld", fq_vld, 0);
    chk("t3_mreq_vld", mreq_vld, 1);
    chk("t3_mreq_addr", mreq_addr, 32'h0000_0100);
    tick_b();
    wait_first_pc("t3_first_pc", 32'h0000_0100, 20);
    repeat (6) tick();

    // Redirect coinciding with a request fire and a response arrival.
    lat = 2;
    repeat (8) tick();
    redir_vld = 1'b1;
    redir_pc  = 32'h0000_2000;
    tick_a();
    chk("t4_fire_in_redir", mreq_vld, 1);
    tick_b();
    redir_vld = 1'b0;
    tick_a();
    chk("t4_fq_vld", fq_vld, 0);
    tick_b();
    wait_first_pc("t4_first_pc", 32'h0000_2000, 20);
    repeat (10) tick();

    // Redirect near the top of the address space; bits[1:0] are ignored.
    lat       = 1;
    redir_vld = 1'b1;
    redir_pc  = 32'hFFFF_FFFF;
    tick();
    redir_vld = 1'b0;
    tick_a();
    chk("t5_mreq_addr", mreq_addr, 32'hFFFF_FFFC);
    tick_b();
    wait_first_pc("t5_first_pc", 32'hFFFF_FFFC, 20);
    wait_first_pc("t5_wrap_pc", 32'h0000_0000, 10);
    repeat (5) tick();

    // Random back-pressure, pops and redirects, including a mid-stream reset.
    for (int ph = 0; ph < 3; ph++) begin
      lat = ph + 1;
      for (int i = 0; i < 100; i++) begin
        mreq_rdy  = ($urandom % 4) != 0;
        fq_pop    = ($urandom % 3) != 0;
        redir_vld = ($urandom % 25) == 0;
        redir_pc  = $urandom;
        tick();
      end
      redir_vld = 1'b0;
      if (ph == 1) do_reset();
    end

    // Drain: stop issuing and consume everything that is left.
    mreq_rdy = 1'b1;
    fq_pop   = 1'b1;
    repeat (10) tick();
    mreq_rdy = 1'b0;
    repeat (12) tick();
    tick_a();
    chk("drain_fq_vld", fq_vld, 0);
    chk("drain_sb_empty", expq.size(), 0);
    tick_b();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "timeout");
  end

endmodule
